fpga_ip_demo_sysid_checker: RTL and testbench



---
 rtl/fpga_ip_demo_pkg.sv | 18 +
 rtl/fpga_ip_demo_sysid_checker.sv | 190 +++++++++++++++++++
 tb/tb_fpga_ip_demo_sysid_checker.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fpga_ip_demo_pkg.sv
// Shared types and constants for the fpga_ip_demo system-ID consumers.
package fpga_ip_demo_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_RD_ID  = 3'd1,
      ST_LAT_ID = 3'd2,
      ST_RD_TS  = 3'd3,
      ST_LAT_TS = 3'd4,
      ST_CHECK  = 3'd5,
      ST_FIN    = 3'd6
   } sysid_chk_state_t;

   localparam logic SYSID_ADDR_ID = 1'b0;
   localparam logic SYSID_ADDR_TS = 1'b1;
   localparam int   SYSID_DATA_W  = 32;

endpackage

// File: rtl/fpga_ip_demo_sysid_checker.sv
// Avalon-MM master that reads the sysid ID and timestamp words and flags
// whether they match the build-time values, with per-read timeout and retry.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | after reset; launches on autostart flag or start pulse
// RD_ID     | read strobe at address 0 (read low for one cycle = retry gap)
// LAT_ID    | ID read accepted, waiting READ_LATENCY cycles for data
// RD_TS     | read strobe at address 1 (read low for one cycle = retry gap)
// LAT_TS    | timestamp read accepted, waiting for data
// CHECK     | compare captured words against expected values
// FIN       | done; status held, start pulse re-runs the check
module fpga_ip_demo_sysid_checker
   import fpga_ip_demo_pkg::*;
#(
   parameter logic [31:0] EXPECTED_ID        = 32'd0,
   parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1619608186,
   parameter int unsigned READ_LATENCY       = 0,
   parameter int unsigned TIMEOUT_CYCLES     = 255,
   parameter int unsigned RETRY_MAX          = 3
) (
   input  logic                    clock,
   input  logic                    reset_n,
   input  logic                    start,
   output logic                    avm_address,
   output logic                    avm_read,
   input  logic [SYSID_DATA_W-1:0] avm_readdata,
   input  logic                    avm_waitrequest,
   output logic [SYSID_DATA_W-1:0] id_value,
   output logic [SYSID_DATA_W-1:0] timestamp_value,
   output logic                    busy,
   output logic                    done,
   output logic                    match,
   output logic                    timeout_err
);

   localparam bit          NO_LAT    = (READ_LATENCY == 0);
   localparam logic [1:0]  LAT_LOAD  = (READ_LATENCY > 0) ? 2'(READ_LATENCY - 1) : 2'd0;
   localparam logic [15:0] TMO_LOAD  = 16'(TIMEOUT_CYCLES - 1);
   localparam logic [2:0]  RETRY_LIM = 3'(RETRY_MAX);

   sysid_chk_state_t state, state_nxt;

   logic                    autostart, autostart_d;
   logic                    read_d, addr_d;
   logic [SYSID_DATA_W-1:0] id_d, ts_d;
   logic                    busy_d, done_d, match_d, terr_d;
   logic [15:0]             tmo_cnt, tmo_cnt_d;
   logic [1:0]              lat_cnt, lat_cnt_d;
   logic [2:0]              retry_cnt, retry_cnt_d;

   logic in_rd, in_lat, in_id, accept, capture, expired, give_up, launch;

   assign in_rd   = (state == ST_RD_ID) || (state == ST_RD_TS);
   assign in_lat  = (state == ST_LAT_ID) || (state == ST_LAT_TS);
   assign in_id   = (state == ST_RD_ID) || (state == ST_LAT_ID);
   assign accept  = avm_read && !avm_waitrequest;
   assign capture = (in_rd && accept && NO_LAT) || (in_lat && (lat_cnt == 2'd0));
   // Timer is a down-counter over the whole attempt (stall plus latency).
   assign expired = (in_lat || (in_rd && avm_read)) && (tmo_cnt == 16'd0) && !capture;
   assign give_up = expired && (retry_cnt == RETRY_LIM);
   assign launch  = ((state == ST_IDLE) && (autostart || start)) ||
                    ((state == ST_FIN) && start);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state           <= ST_IDLE;
         autostart       <= 1'b1;
         avm_read        <= 1'b0;
         avm_address     <= SYSID_ADDR_ID;
         id_value        <= '0;
         timestamp_value <= '0;
         busy            <= 1'b0;
         done            <= 1'b0;
         match           <= 1'b0;
         timeout_err     <= 1'b0;
         tmo_cnt         <= '0;
         lat_cnt         <= '0;
         retry_cnt       <= '0;
      end else begin
         state           <= state_nxt;
         autostart       <= autostart_d;
         avm_read        <= read_d;
         avm_address     <= addr_d;
         id_value        <= id_d;
         timestamp_value <= ts_d;
         busy            <= busy_d;
         done            <= done_d;
         match           <= match_d;
         timeout_err     <= terr_d;
         tmo_cnt         <= tmo_cnt_d;
         lat_cnt         <= lat_cnt_d;
         retry_cnt       <= retry_cnt_d;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE, ST_FIN: if (launch) state_nxt = ST_RD_ID;
         ST_RD_ID: begin
            if (give_up)      state_nxt = ST_FIN;
            else if (expired) state_nxt = ST_RD_ID;
            else if (capture) state_nxt = ST_RD_TS;
            else if (accept)  state_nxt = ST_LAT_ID;
         end
         ST_LAT_ID: begin
            if (give_up)      state_nxt = ST_FIN;
            else if (expired) state_nxt = ST_RD_ID;
            else if (capture) state_nxt = ST_RD_TS;
         end
         ST_RD_TS: begin
            if (give_up)      state_nxt = ST_FIN;
            else if (expired) state_nxt = ST_RD_TS;
            else if (capture) state_nxt = ST_CHECK;
            else if (accept)  state_nxt = ST_LAT_TS;
         end
         ST_LAT_TS: begin
            if (give_up)      state_nxt = ST_FIN;
            else if (expired) state_nxt = ST_RD_TS;
            else if (capture) state_nxt = ST_CHECK;
         end
         ST_CHECK: state_nxt = ST_FIN;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      autostart_d = autostart;
      read_d      = avm_read;
      addr_d      = avm_address;
      id_d        = id_value;
      ts_d        = timestamp_value;
      busy_d      = busy;
      done_d      = done;
      match_d     = match;
      terr_d      = timeout_err;
      tmo_cnt_d   = tmo_cnt;
      lat_cnt_d   = lat_cnt;
      retry_cnt_d = retry_cnt;

      if (launch) begin
         autostart_d = 1'b0;
         read_d      = 1'b1;
         addr_d      = SYSID_ADDR_ID;
         busy_d      = 1'b1;
         done_d      = 1'b0;
         match_d     = 1'b0;
         terr_d      = 1'b0;
         tmo_cnt_d   = TMO_LOAD;
         retry_cnt_d = '0;
      end else if (give_up) begin
         read_d = 1'b0;
         busy_d = 1'b0;
         done_d = 1'b1;
         terr_d = 1'b1;
         match_d = 1'b0;
      end else if (expired) begin
         // Drop the strobe for one cycle; the gap cycle below re-raises it.
         read_d      = 1'b0;
         tmo_cnt_d   = TMO_LOAD;
         retry_cnt_d = retry_cnt + 3'd1;
      end else if (capture) begin
         if (in_id) begin
            id_d        = avm_readdata;
            addr_d      = SYSID_ADDR_TS;
            read_d      = 1'b1;
            tmo_cnt_d   = TMO_LOAD;
            retry_cnt_d = '0;
         end else begin
            ts_d   = avm_readdata;
            read_d = 1'b0;
         end
      end else if (in_rd && !avm_read) begin
         read_d = 1'b1;
      end else if (in_rd && accept) begin
         read_d    = 1'b0;
         lat_cnt_d = LAT_LOAD;
         tmo_cnt_d = tmo_cnt - 16'd1;
      end else if (in_rd || in_lat) begin
         tmo_cnt_d = tmo_cnt - 16'd1;
         if (in_lat) lat_cnt_d = lat_cnt - 2'd1;
      end else if (state == ST_CHECK) begin
         match_d = (id_value == EXPECTED_ID) && (timestamp_value == EXPECTED_TIMESTAMP);
         done_d  = 1'b1;
         busy_d  = 1'b0;
      end
   end

endmodule

// File: tb/tb_fpga_ip_demo_sysid_checker.sv
// Self-checking bench: three checker instances (nominal, latency 2, short timeout)
// driven by behavioural sysid slave models and compared against a result model.
module tb_fpga_ip_demo_sysid_checker;
   import fpga_ip_demo_pkg::*;

   localparam logic [31:0] EXP_ID  = 32'd0;
   localparam logic [31:0] EXP_TS  = 32'd1619608186;
   localparam logic [31:0] GARBAGE = 32'hA5A5_A5A5;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   int vectors = 0;
   int miscompares = 0;

   logic        rst0_n, start0, addr0, read0, wait0, busy0, done0, match0, terr0;
   logic [31:0] rdata0, id0, ts0, id_w0, ts_w0;
   logic        rst1_n, start1, addr1, read1, wait1, busy1, done1, match1, terr1;
   logic [31:0] rdata1, id1, ts1;
   logic        rst2_n, start2, addr2, read2, wait2, busy2, done2, match2, terr2;
   logic [31:0] rdata2, id2, ts2;

   assign rdata0 = addr0 ? ts_w0 : id_w0;

   fpga_ip_demo_sysid_checker u_dut0 (
      .clock(clock), .reset_n(rst0_n), .start(start0),
      .avm_address(addr0), .avm_read(read0), .avm_readdata(rdata0), .avm_waitrequest(wait0),
      .id_value(id0), .timestamp_value(ts0), .busy(busy0), .done(done0),
      .match(match0), .timeout_err(terr0));

   fpga_ip_demo_sysid_checker #(.READ_LATENCY(2)) u_dut1 (
      .clock(clock), .reset_n(rst1_n), .start(start1),
      .avm_address(addr1), .avm_read(read1), .avm_readdata(rdata1), .avm_waitrequest(wait1),
      .id_value(id1), .timestamp_value(ts1), .busy(busy1), .done(done1),
      .match(match1), .timeout_err(terr1));

   fpga_ip_demo_sysid_checker #(.TIMEOUT_CYCLES(8), .RETRY_MAX(1)) u_dut2 (
      .clock(clock), .reset_n(rst2_n), .start(start2),
      .avm_address(addr2), .avm_read(read2), .avm_readdata(rdata2), .avm_waitrequest(wait2),
      .id_value(id2), .timestamp_value(ts2), .busy(busy2), .done(done2),
      .match(match2), .timeout_err(terr2));

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      rst0_n = 0; rst1_n = 0; rst2_n = 0;
      start0 = 0; start1 = 0; start2 = 0;
      wait0 = 0; wait1 = 0; wait2 = 1;
      rdata1 = GARBAGE; rdata2 = 32'd0;
      id_w0 = EXP_ID; ts_w0 = EXP_TS;
      tick(); tick();
      vectors++; if (read0 !== 1'b0) begin miscompares++; $display("FAIL reset_read: got %b want 0", read0); end
      vectors++; if (addr0 !== 1'b0) begin miscompares++; $display("FAIL reset_addr: got %b want 0", addr0); end
      vectors++; if (id0 !== 32'd0) begin miscompares++; $display("FAIL reset_id: got %h want 0", id0); end
      vectors++; if (ts0 !== 32'd0) begin miscompares++; $display("FAIL reset_ts: got %h want 0", ts0); end
      vectors++; if (busy0 !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy0); end
      vectors++; if (done0 !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b want 0", done0); end
      vectors++; if (match0 !== 1'b0) begin miscompares++; $display("FAIL reset_match: got %b want 0", match0); end
      vectors++; if (terr0 !== 1'b0) begin miscompares++; $display("FAIL reset_terr: got %b want 0", terr0); end
      vectors++; if (read1 !== 1'b0 || read2 !== 1'b0) begin miscompares++; $display("FAIL reset_read_others: got %b%b want 00", read1, read2); end
   endtask

   task automatic test_nominal();
      id_w0 = EXP_ID; ts_w0 = EXP_TS; wait0 = 0;
      rst0_n = 1;
      tick();
      vectors++; if (read0 !== 1'b1 || addr0 !== 1'b0) begin miscompares++; $display("FAIL nominal_e1: read/addr got %b/%b want 1/0", read0, addr0); end
      vectors++; if (busy0 !== 1'b1) begin miscompares++; $display("FAIL nominal_e1_busy: got %b want 1", busy0); end
      tick();
      vectors++; if (read0 !== 1'b1 || addr0 !== 1'b1) begin miscompares++; $display("FAIL nominal_e2: read/addr got %b/%b want 1/1", read0, addr0); end
      tick();
      vectors++; if (read0 !== 1'b0 || done0 !== 1'b0) begin miscompares++; $display("FAIL nominal_e3: read/done got %b/%b want 0/0", read0, done0); end
      tick();
      vectors++; if (done0 !== 1'b1) begin miscompares++; $display("FAIL nominal_e4_done: got %b want 1", done0); end
      vectors++; if (match0 !== 1'b1) begin miscompares++; $display("FAIL nominal_match: got %b want 1", match0); end
      vectors++; if (terr0 !== 1'b0) begin miscompares++; $display("FAIL nominal_terr: got %b want 0", terr0); end
      vectors++; if (busy0 !== 1'b0) begin miscompares++; $display("FAIL nominal_busy: got %b want 0", busy0); end
      vectors++; if (ts0 !== EXP_TS) begin miscompares++; $display("FAIL nominal_ts: got %h want %h", ts0, EXP_TS); end
   endtask

   task automatic test_mismatch();
      id_w0 = 32'h1234_5678; ts_w0 = EXP_TS; wait0 = 0;
      start0 = 1; tick(); start0 = 0;
      vectors++; if (busy0 !== 1'b1 || done0 !== 1'b0) begin miscompares++; $display("FAIL mismatch_launch: busy/done got %b/%b want 1/0", busy0, done0); end
      for (int c = 0; c < 50 && !done0; c++) tick();
      vectors++; if (done0 !== 1'b1) begin miscompares++; $display("FAIL mismatch_done: got %b want 1", done0); end
      vectors++; if (match0 !== 1'b0) begin miscompares++; $display("FAIL mismatch_match: got %b want 0", match0); end
      vectors++; if (id0 !== 32'h1234_5678) begin miscompares++; $display("FAIL mismatch_id: got %h want 12345678", id0); end
      vectors++; if (terr0 !== 1'b0) begin miscompares++; $display("FAIL mismatch_terr: got %b want 0", terr0); end
   endtask

   task automatic test_random();
      logic prev_read, prev_wait, prev_addr;
      logic acc_addr [4];
      int   acc_n, streak, pct;
      logic exp_match;
      for (int it = 0; it < 25; it++) begin
         id_w0 = ($urandom_range(0, 1) == 1) ? EXP_ID : $urandom();
         ts_w0 = ($urandom_range(0, 1) == 1) ? EXP_TS : $urandom();
         exp_match = (id_w0 == EXP_ID) && (ts_w0 == EXP_TS);
         pct = $urandom_range(0, 60);
         wait0 = 0;
         start0 = 1; tick(); start0 = 0;
         vectors++; if (busy0 !== 1'b1 || done0 !== 1'b0) begin miscompares++; $display("FAIL rand_launch[%0d]: busy/done got %b/%b want 1/0", it, busy0, done0); end
         prev_read = 0; prev_wait = 0; prev_addr = 0; acc_n = 0; streak = 0;
         for (int c = 0; c < 200 && !done0; c++) begin
            if (prev_read && prev_wait) begin
               vectors++;
               if (read0 !== 1'b1 || addr0 !== prev_addr) begin
                  miscompares++;
                  $display("FAIL rand_stall_hold[%0d]: read/addr got %b/%b want 1/%b", it, read0, addr0, prev_addr);
               end
            end
            wait0 = read0 && (streak < 10) && ($urandom_range(0, 99) < pct);
            streak = wait0 ? streak + 1 : 0;
            if (read0 && !wait0) begin
               if (acc_n < 4) acc_addr[acc_n] = addr0;
               acc_n++;
            end
            prev_read = read0; prev_wait = wait0; prev_addr = addr0;
            tick();
         end
         wait0 = 0;
         vectors++; if (done0 !== 1'b1) begin miscompares++; $display("FAIL rand_done[%0d]: got %b want 1", it, done0); end
         vectors++; if (acc_n != 2) begin miscompares++; $display("FAIL rand_reads[%0d]: got %0d want 2", it, acc_n); end
         else begin
            vectors++; if (acc_addr[0] !== 1'b0 || acc_addr[1] !== 1'b1) begin miscompares++; $display("FAIL rand_order[%0d]: got %b,%b want 0,1", it, acc_addr[0], acc_addr[1]); end
         end
         vectors++; if (id0 !== id_w0) begin miscompares++; $display("FAIL rand_id[%0d]: got %h want %h", it, id0, id_w0); end
         vectors++; if (ts0 !== ts_w0) begin miscompares++; $display("FAIL rand_ts[%0d]: got %h want %h", it, ts0, ts_w0); end
         vectors++; if (match0 !== exp_match) begin miscompares++; $display("FAIL rand_match[%0d]: got %b want %b", it, match0, exp_match); end
         vectors++; if (terr0 !== 1'b0 || busy0 !== 1'b0) begin miscompares++; $display("FAIL rand_status[%0d]: terr/busy got %b/%b want 0/0", it, terr0, busy0); end
      end
   endtask

   task automatic test_back_to_back();
      int   acc_n, rises;
      logic prev_done;
      id_w0 = EXP_ID; ts_w0 = EXP_TS; wait0 = 0;
      acc_n = 0; rises = 0;
      start0 = 1; tick(); start0 = 0;
      vectors++; if (done0 !== 1'b0 || busy0 !== 1'b1) begin miscompares++; $display("FAIL b2b_launch: done/busy got %b/%b want 0/1", done0, busy0); end
      if (read0 && !wait0) acc_n++;
      prev_done = done0;
      tick();
      start0 = 1;
      for (int c = 0; c < 20; c++) begin
         if (read0 && !wait0) acc_n++;
         if (done0 && !prev_done) rises++;
         prev_done = done0;
         tick();
         start0 = 0;
      end
      vectors++; if (acc_n != 2) begin miscompares++; $display("FAIL b2b_reads: got %0d want 2", acc_n); end
      vectors++; if (rises != 1) begin miscompares++; $display("FAIL b2b_done_rises: got %0d want 1", rises); end
      vectors++; if (done0 !== 1'b1 || match0 !== 1'b1 || busy0 !== 1'b0) begin miscompares++; $display("FAIL b2b_final: done/match/busy got %b/%b/%b want 1/1/0", done0, match0, busy0); end
   endtask

   task automatic test_mid_reset();
      logic [31:0] junk;
      junk = $urandom() | 32'h1;
      id_w0 = junk; ts_w0 = EXP_TS; wait0 = 0;
      rst0_n = 0; tick(); rst0_n = 1;
      tick(); tick();
      vectors++; if (read0 !== 1'b1 || addr0 !== 1'b1 || id0 !== junk) begin miscompares++; $display("FAIL midrst_in_rdts: read/addr/id got %b/%b/%h want 1/1/%h", read0, addr0, id0, junk); end
      rst0_n = 0;
      #1;
      vectors++; if (read0 !== 1'b0 || addr0 !== 1'b0 || busy0 !== 1'b0 || done0 !== 1'b0) begin miscompares++; $display("FAIL midrst_ctrl: read/addr/busy/done got %b/%b/%b/%b want 0/0/0/0", read0, addr0, busy0, done0); end
      vectors++; if (id0 !== 32'd0 || ts0 !== 32'd0 || match0 !== 1'b0 || terr0 !== 1'b0) begin miscompares++; $display("FAIL midrst_data: id/ts/match/terr got %h/%h/%b/%b want 0/0/0/0", id0, ts0, match0, terr0); end
      id_w0 = EXP_ID;
      for (int c = 0; c < 3; c++) begin
         tick();
         vectors++; if (read0 !== 1'b0 || busy0 !== 1'b0) begin miscompares++; $display("FAIL midrst_hold[%0d]: read/busy got %b/%b want 0/0", c, read0, busy0); end
      end
      rst0_n = 1;
      for (int c = 0; c < 20 && !done0; c++) tick();
      vectors++; if (done0 !== 1'b1 || match0 !== 1'b1) begin miscompares++; $display("FAIL midrst_rerun: done/match got %b/%b want 1/1", done0, match0); end
      vectors++; if (id0 !== EXP_ID || ts0 !== EXP_TS) begin miscompares++; $display("FAIL midrst_words: id/ts got %h/%h want %h/%h", id0, ts0, EXP_ID, EXP_TS); end
   endtask

   task automatic test_latency();
      int   cyc, data_cyc, stall, acc_n;
      logic data_addr, prev_read, prev_wait, prev_addr, prev_acc;
      logic acc_addr [4];
      cyc = 0; data_cyc = -1; data_addr = 0; stall = 0; acc_n = 0;
      prev_read = 0; prev_wait = 0; prev_addr = 0; prev_acc = 0;
      rst1_n = 1;
      tick();
      for (int c = 0; c < 100 && !done1; c++) begin
         if (prev_read && prev_wait) begin
            vectors++; if (read1 !== 1'b1 || addr1 !== prev_addr) begin miscompares++; $display("FAIL lat_stall_hold: read/addr got %b/%b want 1/%b", read1, addr1, prev_addr); end
         end
         if (prev_acc) begin
            vectors++; if (read1 !== 1'b0) begin miscompares++; $display("FAIL lat_read_drop: got %b want 0", read1); end
         end
         rdata1 = (cyc == data_cyc) ? (data_addr ? EXP_TS : EXP_ID) : GARBAGE;
         prev_acc = 0;
         if (read1) begin
            if (stall < 5) begin
               wait1 = 1; stall++;
            end else begin
               wait1 = 0; stall = 0; prev_acc = 1;
               data_cyc = cyc + 2; data_addr = addr1;
               if (acc_n < 4) acc_addr[acc_n] = addr1;
               acc_n++;
            end
         end else begin
            wait1 = 0;
         end
         prev_read = read1; prev_wait = wait1; prev_addr = addr1;
         tick();
         cyc++;
      end
      vectors++; if (done1 !== 1'b1) begin miscompares++; $display("FAIL lat_done: got %b want 1", done1); end
      vectors++; if (acc_n != 2) begin miscompares++; $display("FAIL lat_reads: got %0d want 2", acc_n); end
      else begin
         vectors++; if (acc_addr[0] !== 1'b0 || acc_addr[1] !== 1'b1) begin miscompares++; $display("FAIL lat_order: got %b,%b want 0,1", acc_addr[0], acc_addr[1]); end
      end
      vectors++; if (id1 !== EXP_ID || ts1 !== EXP_TS) begin miscompares++; $display("FAIL lat_words: id/ts got %h/%h want %h/%h", id1, ts1, EXP_ID, EXP_TS); end
      vectors++; if (match1 !== 1'b1 || terr1 !== 1'b0) begin miscompares++; $display("FAIL lat_status: match/terr got %b/%b want 1/0", match1, terr1); end
   endtask

   task automatic test_timeout();
      int   seg_len [4];
      int   seg_n, gaps;
      logic prev_read;
      seg_n = 0; gaps = 0; prev_read = 0;
      for (int i = 0; i < 4; i++) seg_len[i] = 0;
      rst2_n = 1;
      tick();
      for (int c = 0; c < 60 && !done2; c++) begin
         if (read2) begin
            if (!prev_read) seg_n++;
            if (seg_n > 0 && seg_n <= 4) seg_len[seg_n-1]++;
            vectors++; if (addr2 !== 1'b0) begin miscompares++; $display("FAIL tmo_addr: got %b want 0", addr2); end
         end else if (seg_n > 0) begin
            gaps++;
         end
         prev_read = read2;
         tick();
      end
      vectors++; if (seg_n != 2) begin miscompares++; $display("FAIL tmo_attempts: got %0d want 2", seg_n); end
      vectors++; if (seg_len[0] != 8 || seg_len[1] != 8) begin miscompares++; $display("FAIL tmo_attempt_len: got %0d,%0d want 8,8", seg_len[0], seg_len[1]); end
      vectors++; if (gaps != 1) begin miscompares++; $display("FAIL tmo_gap: got %0d want 1", gaps); end
      vectors++; if (done2 !== 1'b1 || terr2 !== 1'b1) begin miscompares++; $display("FAIL tmo_flags: done/terr got %b/%b want 1/1", done2, terr2); end
      vectors++; if (match2 !== 1'b0 || busy2 !== 1'b0 || read2 !== 1'b0) begin miscompares++; $display("FAIL tmo_status: match/busy/read got %b/%b/%b want 0/0/0", match2, busy2, read2); end
      vectors++; if (id2 !== 32'd0 || ts2 !== 32'd0) begin miscompares++; $display("FAIL tmo_words: id/ts got %h/%h want 0/0", id2, ts2); end
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_mismatch();
      test_random();
      test_back_to_back();
      test_mid_reset();
      test_latency();
      test_timeout();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
